// File: rtl/branch_predictor.sv
// IF-stage branch predictor: a direct-mapped BTB with saturating direction counters,
// plus a circular return-address stack trained at resolve time from the ID stage.
module branch_predictor #(
  parameter int ADDR_W    = 32,
  parameter int ENTRIES   = 64,
  parameter int CNT_W     = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic              pred_hit,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [1:0]        upd_type,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target
);
  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int TAG_W  = ADDR_W - IDX_W - 2;
  localparam int PTR_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int RCNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [1:0] TYPE_BR   = 2'b00;
  localparam logic [1:0] TYPE_CALL = 2'b10;
  localparam logic [1:0] TYPE_RET  = 2'b11;

  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_WEAK  = CNT_W'(1'b1) << (CNT_W - 1);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(32'd4);
  localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(RAS_DEPTH - 1);
  localparam logic [RCNT_W-1:0] RCNT_ZERO = {RCNT_W{1'b0}};
  localparam logic [RCNT_W-1:0] RCNT_FULL = RCNT_W'(RAS_DEPTH);

  logic [ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [1:0]         type_r   [ENTRIES];
  logic [ADDR_W-1:0]  target_r [ENTRIES];
  logic [CNT_W-1:0]   cnt_r    [ENTRIES];
  logic [ADDR_W-1:0]  ras_r    [RAS_DEPTH];
  logic [PTR_W-1:0]   ras_ptr_r;
  logic [RCNT_W-1:0]  ras_cnt_r;

  logic [IDX_W-1:0]  lk_idx_s;
  logic [IDX_W-1:0]  up_idx_s;
  logic [TAG_W-1:0]  lk_tag_s;
  logic [TAG_W-1:0]  up_tag_s;
  logic              lk_hit_s;
  logic              up_hit_s;
  logic              ras_empty_s;
  logic [PTR_W-1:0]  ptr_inc_s;
  logic [PTR_W-1:0]  ptr_dec_s;
  logic [ADDR_W-1:0] ras_top_s;
  logic [ADDR_W-1:0] fall_thru_s;
  logic [CNT_W-1:0]  cnt_next_s;

  // RAS pointer arithmetic; the pointer names the next free slot, so the top sits one below it.
  always_comb begin
    ras_empty_s = (ras_cnt_r == RCNT_ZERO);
    ptr_inc_s   = (ras_ptr_r == PTR_LAST) ? PTR_ZERO : ras_ptr_r + PTR_W'(1'b1);
    ptr_dec_s   = (ras_ptr_r == PTR_ZERO) ? PTR_LAST : ras_ptr_r - PTR_W'(1'b1);
    ras_top_s   = ras_r[ptr_dec_s];
  end

  // Zero-latency lookup from registered state; reset forces a miss while it is held.
  always_comb begin
    lk_idx_s    = if_pc[IDX_W+1:2];
    lk_tag_s    = if_pc[ADDR_W-1:IDX_W+2];
    fall_thru_s = if_pc + PC_STEP;
    lk_hit_s    = if_valid & ~reset & valid_r[lk_idx_s] & (tag_r[lk_idx_s] == lk_tag_s);
    pred_hit    = lk_hit_s;
    pred_taken  = 1'b0;
    pred_target = fall_thru_s;
    if (lk_hit_s) begin
      case (type_r[lk_idx_s])
        TYPE_BR:  pred_taken = cnt_r[lk_idx_s][CNT_W-1];
        TYPE_RET: pred_taken = ~ras_empty_s;
        default:  pred_taken = 1'b1;
      endcase
    end else begin
      pred_taken = 1'b0;
    end
    if (pred_taken) begin
      pred_target = (type_r[lk_idx_s] == TYPE_RET) ? ras_top_s : target_r[lk_idx_s];
    end else begin
      pred_target = fall_thru_s;
    end
  end

  // Update-side tag check and saturating counter step.
  always_comb begin
    up_idx_s = upd_pc[IDX_W+1:2];
    up_tag_s = upd_pc[ADDR_W-1:IDX_W+2];
    up_hit_s = valid_r[up_idx_s] & (tag_r[up_idx_s] == up_tag_s);
    if (upd_taken) begin
      cnt_next_s = (cnt_r[up_idx_s] == CNT_MAX) ? CNT_MAX : cnt_r[up_idx_s] + CNT_W'(1'b1);
    end else begin
      cnt_next_s = (cnt_r[up_idx_s] == CNT_ZERO) ? CNT_ZERO : cnt_r[up_idx_s] - CNT_W'(1'b1);
    end
  end

  // Valid bits: the only table state that reset clears. Not-taken misses never allocate.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= {ENTRIES{1'b0}};
    end else if (upd_valid && !up_hit_s && upd_taken) begin
      valid_r[up_idx_s] <= 1'b1;
    end
  end

  // Entry payload: train counter on hit, overwrite type/target only when taken.
  always_ff @(posedge clk) begin
    if (!reset && upd_valid) begin
      if (up_hit_s) begin
        cnt_r[up_idx_s] <= cnt_next_s;
        if (upd_taken) begin
          type_r[up_idx_s]   <= upd_type;
          target_r[up_idx_s] <= upd_target;
        end
      end else if (upd_taken) begin
        tag_r[up_idx_s]    <= up_tag_s;
        type_r[up_idx_s]   <= upd_type;
        target_r[up_idx_s] <= upd_target;
        cnt_r[up_idx_s]    <= (upd_type == TYPE_BR) ? CNT_WEAK : CNT_MAX;
      end
    end
  end

  // Return-address stack: a push when full overwrites the oldest slot; pop on empty is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ptr_r <= PTR_ZERO;
      ras_cnt_r <= RCNT_ZERO;
    end else if (upd_valid && (upd_type == TYPE_CALL)) begin
      ras_r[ras_ptr_r] <= upd_pc + PC_STEP;
      ras_ptr_r        <= ptr_inc_s;
      if (ras_cnt_r != RCNT_FULL) begin
        ras_cnt_r <= ras_cnt_r + RCNT_W'(1'b1);
      end
    end else if (upd_valid && (upd_type == TYPE_RET) && !ras_empty_s) begin
      ras_ptr_r <= ptr_dec_s;
      ras_cnt_r <= ras_cnt_r - RCNT_W'(1'b1);
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// compared against a queue/array reference model of the prediction rules.
module tb_branch_predictor;
  localparam int N     = 64;
  localparam int DEPTH = 4;
  localparam logic [1:0] BR = 2'b00, JMP = 2'b01, CALL = 2'b10, RET = 2'b11;

  logic        clk = 1'b0;
  logic        reset, if_valid, upd_valid, upd_taken, pred_taken, pred_hit;
  logic [31:0] if_pc, pred_target, upd_pc, upd_target;
  logic [1:0]  upd_type;
  int tests = 0;
  int fails = 0;

  bit          m_v   [N];
  logic [31:0] m_tag [N];
  logic [1:0]  m_typ [N];
  logic [31:0] m_tgt [N];
  int          m_cnt [N];
  logic [31:0] m_ras [$];

  branch_predictor dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_hit(pred_hit),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_type(upd_type),
    .upd_taken(upd_taken), .upd_target(upd_target)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic m_predict(output bit h, output bit t, output logic [31:0] tg);
    int unsigned i = (if_pc >> 2) % N;
    h = if_valid && !reset && m_v[i] && (m_tag[i] == (if_pc >> 8));
    t = 1'b0;
    if (h) t = (m_typ[i] == BR) ? (m_cnt[i] >= 2) : (m_typ[i] == RET) ? (m_ras.size() > 0) : 1'b1;
    tg = !t ? if_pc + 32'd4 : (m_typ[i] == RET) ? m_ras[$] : m_tgt[i];
  endtask

  task automatic m_clock();
    int unsigned i = (upd_pc >> 2) % N;
    bit h = m_v[i] && (m_tag[i] == (upd_pc >> 8));
    if (reset) begin
      foreach (m_v[k]) m_v[k] = 1'b0;
      m_ras.delete();
    end else if (upd_valid) begin
      if (h) begin
        m_cnt[i] = upd_taken ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3) : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
        if (upd_taken) begin m_typ[i] = upd_type; m_tgt[i] = upd_target; end
      end else if (upd_taken) begin
        m_v[i] = 1'b1; m_tag[i] = upd_pc >> 8; m_typ[i] = upd_type; m_tgt[i] = upd_target;
        m_cnt[i] = (upd_type == BR) ? 2 : 3;
      end
      if (upd_type == CALL) begin
        m_ras.push_back(upd_pc + 32'd4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end else if (upd_type == RET && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic upd(input logic [1:0] t, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    upd_valid = 1'b1; upd_type = t; upd_pc = pc; upd_taken = tk; upd_target = tg;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    if_valid = 1'b1; if_pc = pc;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    look(32'h40);
    tests++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h44}) begin
      fails++; $display("FAIL reset_during: got %b %b %h want 0 0 00000044", pred_hit, pred_taken, pred_target);
    end
    tick();
    reset = 1'b0;
    look(32'h40);
    tests++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h44}) begin
      fails++; $display("FAIL reset_after: got %b %b %h want 0 0 00000044", pred_hit, pred_taken, pred_target);
    end
    look(32'hFFFF_FFFC);
    tests++;
    if (pred_target !== 32'h0) begin
      fails++; $display("FAIL pc_wrap: got target %h want 00000000", pred_target);
    end
    upd(BR, 32'h40, 1'b0, 32'h100);
    look(32'h40);
    tests++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h44}) begin
      fails++; $display("FAIL no_alloc_nt: got %b %b %h want 0 0 00000044", pred_hit, pred_taken, pred_target);
    end
    if_valid = 1'b0;
    #1;
    tests++;
    if ({pred_hit, pred_taken} !== 2'b00) begin
      fails++; $display("FAIL if_valid_low: got hit=%b taken=%b want 0 0", pred_hit, pred_taken);
    end
  endtask

  task automatic test_branch_train();
    logic [32:0] exp_ht [4];
    exp_ht = '{{1'b1, 32'h100}, {1'b0, 32'h44}, {1'b0, 32'h44}, {1'b0, 32'h44}};
    upd(BR, 32'h40, 1'b1, 32'h100);
    for (int k = 0; k < 4; k++) begin
      look(32'h40);
      tests++;
      if ({pred_hit, pred_taken, pred_target} !== {1'b1, exp_ht[k]}) begin
        fails++; $display("FAIL train_step%0d: got %b %b %h want 1 %b %h", k, pred_hit, pred_taken, pred_target, exp_ht[k][32], exp_ht[k][31:0]);
      end
      upd(BR, 32'h40, (k == 2), 32'h100);
    end
  endtask

  task automatic test_saturation_alias();
    for (int k = 0; k < 4; k++) upd(BR, 32'h40, 1'b1, 32'h100);
    look(32'h40);
    tests++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h100}) begin
      fails++; $display("FAIL sat_high: got %b %b %h want 1 1 00000100", pred_hit, pred_taken, pred_target);
    end
    upd(BR, 32'h40, 1'b0, 32'h100);
    look(32'h40);
    tests++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h100}) begin
      fails++; $display("FAIL sat_dec1: got %b %b %h want 1 1 00000100", pred_hit, pred_taken, pred_target);
    end
    upd(BR, 32'h40, 1'b0, 32'h100);
    look(32'h40);
    tests++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b0, 32'h44}) begin
      fails++; $display("FAIL sat_dec2: got %b %b %h want 1 0 00000044", pred_hit, pred_taken, pred_target);
    end
    look(32'h140);
    tests++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h144}) begin
      fails++; $display("FAIL alias_miss: got %b %b %h want 0 0 00000144", pred_hit, pred_taken, pred_target);
    end
  endtask

  task automatic test_ras();
    upd(RET, 32'h480, 1'b1, 32'h204);
    upd_valid = 1'b1; upd_type = CALL; upd_pc = 32'h200; upd_taken = 1'b1; upd_target = 32'h400;
    look(32'h480);
    tests++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b0, 32'h484}) begin
      fails++; $display("FAIL ras_old_top: got %b %b %h want 1 0 00000484", pred_hit, pred_taken, pred_target);
    end
    tick();
    upd_valid = 1'b0;
    look(32'h480);
    tests++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h204}) begin
      fails++; $display("FAIL ras_ret: got %b %b %h want 1 1 00000204", pred_hit, pred_taken, pred_target);
    end
    look(32'h200);
    tests++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h400}) begin
      fails++; $display("FAIL call_btb: got %b %b %h want 1 1 00000400", pred_hit, pred_taken, pred_target);
    end
    upd(RET, 32'h480, 1'b1, 32'h204);
    look(32'h480);
    tests++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b0, 32'h484}) begin
      fails++; $display("FAIL ras_popped: got %b %b %h want 1 0 00000484", pred_hit, pred_taken, pred_target);
    end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_pop [4];
    exp_pop = '{32'h54, 32'h44, 32'h34, 32'h24};
    for (int k = 1; k <= 5; k++) upd(CALL, 32'(k * 16), 1'b1, 32'h600);
    for (int k = 0; k < 4; k++) begin
      look(32'h480);
      tests++;
      if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, exp_pop[k]}) begin
        fails++; $display("FAIL ovf_pop%0d: got %b %b %h want 1 1 %h", k, pred_hit, pred_taken, pred_target, exp_pop[k]);
      end
      upd(RET, 32'h480, 1'b1, 32'h0);
    end
    look(32'h480);
    tests++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b0, 32'h484}) begin
      fails++; $display("FAIL ovf_empty: got %b %b %h want 1 0 00000484", pred_hit, pred_taken, pred_target);
    end
    upd(RET, 32'h480, 1'b1, 32'h0);
    upd(CALL, 32'h70, 1'b1, 32'h600);
    look(32'h480);
    tests++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h74}) begin
      fails++; $display("FAIL extra_pop_push: got %b %b %h want 1 1 00000074", pred_hit, pred_taken, pred_target);
    end
    upd(RET, 32'h480, 1'b1, 32'h0);
    look(32'h480);
    tests++;
    if (pred_taken !== 1'b0) begin
      fails++; $display("FAIL extra_pop_count: got taken %b want 0", pred_taken);
    end
  endtask

  task automatic test_read_old();
    reset = 1'b1; tick(); reset = 1'b0;
    upd(BR, 32'h40, 1'b1, 32'h100);
    upd_valid = 1'b1; upd_type = JMP; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h300;
    look(32'h40);
    tests++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h100}) begin
      fails++; $display("FAIL read_old: got %b %b %h want 1 1 00000100", pred_hit, pred_taken, pred_target);
    end
    tick();
    upd_valid = 1'b0;
    look(32'h40);
    tests++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h300}) begin
      fails++; $display("FAIL read_new: got %b %b %h want 1 1 00000300", pred_hit, pred_taken, pred_target);
    end
  endtask

  task automatic test_reset_priority();
    logic [31:0] pcs [3];
    pcs = '{32'h900, 32'h40, 32'h200};
    upd(CALL, 32'h200, 1'b1, 32'h400);
    reset = 1'b1;
    upd_valid = 1'b1; upd_type = BR; upd_pc = 32'h900; upd_taken = 1'b1; upd_target = 32'h500;
    look(32'h40);
    tests++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h44}) begin
      fails++; $display("FAIL rst_hold_lookup: got %b %b %h want 0 0 00000044", pred_hit, pred_taken, pred_target);
    end
    tick();
    reset = 1'b0; upd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      look(pcs[k]);
      tests++;
      if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, pcs[k] + 32'd4}) begin
        fails++; $display("FAIL rst_prio_%h: got %b %b %h want 0 0 %h", pcs[k], pred_hit, pred_taken, pred_target, pcs[k] + 32'd4);
      end
    end
  endtask

  task automatic test_random();
    bit eh, et;
    logic [31:0] etg;
    for (int c = 0; c < 800; c++) begin
      reset      = ($urandom_range(0, 63) == 0);
      if_valid   = ($urandom_range(0, 9) != 0);
      if_pc      = 32'(($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      upd_valid  = ($urandom_range(0, 9) < 7);
      upd_type   = 2'($urandom_range(0, 3));
      upd_pc     = 32'(($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      upd_taken  = (upd_type != BR) ? 1'b1 : 1'($urandom_range(0, 1));
      upd_target = $urandom & 32'hFFFF_FFFC;
      #1;
      m_predict(eh, et, etg);
      tests++;
      if ({pred_hit, pred_taken, pred_target} !== {eh, et, etg}) begin
        fails++; $display("FAIL random_c%0d pc=%h: got %b %b %h want %b %b %h", c, if_pc, pred_hit, pred_taken, pred_target, eh, et, etg);
      end
      tick();
    end
    reset = 1'b0; upd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_pc = 32'h0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_type = BR; upd_taken = 1'b0; upd_target = 32'h0;
    test_reset();
    test_branch_train();
    test_saturation_alias();
    test_ras();
    test_ras_overflow();
    test_read_old();
    test_reset_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
